// File: rtl/io_ctc_responder.sv
`default_nettype none
// ============================================================================
// Module      : io_ctc_responder
// Description : Two-channel memory-mapped counter/timer on the Minisys I/O bus.
//               Each channel counts down from INITn, either on prescaled clock
//               ticks (timer mode) or on synchronized rising edges of
//               pulse_in[n] (pulse-counter mode). Status and current count are
//               returned on a registered read path with 1-cycle latency.
//
//               Ports:
//                 clock, reset   system clock, synchronous active-high reset
//                 ctc_cs         chip select from the I/O address decoder
//                 IORead/IOWrite bus strobes, qualified by ctc_cs
//                 addr[2:1]      register select (addr[0] ignored)
//                 wdata          write data
//                 pulse_in[1:0]  asynchronous external pulse inputs
//                 rdata          registered read data
//                 irq[1:0]       one-cycle terminal-count pulses
//
//               Optional feature macro: CTC_IRQ_EN. When undefined, irq is
//               tied to 2'b00 and no interrupt register is built; DONE and
//               status behaviour are identical in both builds.
// Revision    : 1.0 - initial release
// ============================================================================
module io_ctc_responder #(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctc_cs,
    input  logic             IORead,
    input  logic             IOWrite,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [1:0]       pulse_in,
    output logic [WIDTH-1:0] rdata,
    output logic [1:0]       irq
);

    localparam int                 c_PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0]   c_ONE      = WIDTH'(1);

    // Per-channel state
    logic [1:0]         r_en;
    logic [1:0]         r_mode;
    logic [1:0]         r_rpt;
    logic [1:0]         r_done;
    logic [WIDTH-1:0]   r_init [2];
    logic [WIDTH-1:0]   r_cur  [2];

    // Shared prescaler, pulse synchronizers, read register
    logic [c_PRE_W-1:0] r_presc;
    logic [1:0]         r_sync1;
    logic [1:0]         r_sync2;
    logic [1:0]         r_sync3;
    logic [WIDTH-1:0]   r_rdata;

    logic               w_wr;
    logic               w_rd;
    logic [1:0]         w_sel;
    logic               w_any_timer;
    logic               w_timer_tick;
    logic [1:0]         w_rise;
    logic [1:0]         w_wr_ctrl;
    logic [1:0]         w_wr_init;
    logic [1:0]         w_rd_stat;
    logic [1:0]         w_tick;
    logic [1:0]         w_fire;
    logic [WIDTH-1:0]   w_status [2];
    logic [WIDTH-1:0]   w_rd_val;
    logic               w_unused;

    // addr[0] is a byte-offset bit with no decode meaning
    assign w_unused = addr[0];

    // A simultaneous read+write is treated as a write only
    assign w_wr  = ctc_cs & IOWrite;
    assign w_rd  = ctc_cs & IORead & ~IOWrite;
    assign w_sel = addr[2:1];

    assign w_any_timer  = |(r_en & ~r_mode);
    assign w_timer_tick = w_any_timer && (r_presc == c_PRE_LAST);

    // Edge seen one stage past the 2-FF synchronizer; the count lands on the
    // third clock after the input edge
    assign w_rise = r_sync2 & ~r_sync3;

    for (genvar n = 0; n < 2; n++) begin : g_ch
        assign w_wr_ctrl[n] = w_wr && (w_sel == {1'b0, 1'(n)});
        assign w_wr_init[n] = w_wr && (w_sel == {1'b1, 1'(n)});
        assign w_rd_stat[n] = w_rd && (w_sel == {1'b0, 1'(n)});
        // A register write to this channel in the tick cycle discards the tick
        assign w_tick[n]    = r_en[n]
                              && (r_mode[n] ? w_rise[n] : w_timer_tick)
                              && !w_wr_ctrl[n] && !w_wr_init[n]
                              && (r_cur[n] != '0);
        assign w_fire[n]    = w_tick[n] && (r_cur[n] == c_ONE);
        assign w_status[n]  = {1'b1, {(WIDTH-5){1'b0}},
                               r_rpt[n], r_mode[n], r_done[n], r_en[n]};
    end

    always_comb begin
        w_rd_val = '0;
        case (w_sel)
            2'b00:   w_rd_val = w_status[0];
            2'b01:   w_rd_val = w_status[1];
            2'b10:   w_rd_val = r_cur[0];
            default: w_rd_val = r_cur[1];
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_en   <= '0;
            r_mode <= '0;
            r_rpt  <= '0;
            r_done <= '0;
            for (int n = 0; n < 2; n++) begin
                r_init[n] <= '0;
                r_cur[n]  <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (w_wr_init[n]) begin
                    r_init[n] <= wdata;
                    r_cur[n]  <= wdata;
                end else if (w_wr_ctrl[n]) begin
                    r_en[n]   <= wdata[0];
                    r_mode[n] <= wdata[1];
                    r_rpt[n]  <= wdata[2];
                end else if (w_tick[n]) begin
                    if (r_cur[n] == c_ONE) begin
                        if (r_rpt[n]) begin
                            r_cur[n] <= r_init[n];
                        end else begin
                            r_cur[n] <= '0;
                            r_en[n]  <= 1'b0;
                        end
                    end else begin
                        r_cur[n] <= r_cur[n] - c_ONE;
                    end
                end

                // Terminal-count set beats a status read-clear
                if (w_wr_init[n]) begin
                    r_done[n] <= 1'b0;
                end else if (w_fire[n]) begin
                    r_done[n] <= 1'b1;
                end else if (w_rd_stat[n]) begin
                    r_done[n] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_presc <= '0;
        end else if (!w_any_timer || (r_presc == c_PRE_LAST)) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_PRE_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= pulse_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (w_rd) begin
            r_rdata <= w_rd_val;
        end
    end

    assign rdata = r_rdata;

`ifdef CTC_IRQ_EN
    logic [1:0] r_irq;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_irq <= '0;
        end else begin
            r_irq <= w_fire;
        end
    end

    assign irq = r_irq;
`else
    assign irq = 2'b00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_io_ctc_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_ctc_responder
// Description : Self-checking bench for io_ctc_responder. Directed steps with
//               fixed expected values, followed by randomized bus and pulse
//               traffic compared every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_ctc_responder;

    localparam int WIDTH    = 16;
    localparam int PRESCALE = 4;
`ifdef CTC_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             ctc_cs;
    logic             IORead;
    logic             IOWrite;
    logic [2:0]       addr;
    logic [WIDTH-1:0] wdata;
    logic [1:0]       pulse_in;
    logic [WIDTH-1:0] rdata;
    logic [1:0]       irq;

    io_ctc_responder #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
        .clock    (clock),
        .reset    (reset),
        .ctc_cs   (ctc_cs),
        .IORead   (IORead),
        .IOWrite  (IOWrite),
        .addr     (addr),
        .wdata    (wdata),
        .pulse_in (pulse_in),
        .rdata    (rdata),
        .irq      (irq)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int irq_seen [2];

    // Behavioural model state
    bit          m_en [2];
    bit          m_mode [2];
    bit          m_rpt [2];
    bit          m_done [2];
    logic [15:0] m_init [2];
    logic [15:0] m_cur [2];
    logic [15:0] m_rdata;
    logic [1:0]  m_irq;
    int          m_pcnt;        // cycles elapsed with a timer channel active
    bit          m_hist [2][3]; // recent pulse_in samples, [0] newest

    function automatic logic [15:0] status_word(int n);
        return {1'b1, 11'b0, m_rpt[n], m_mode[n], m_done[n], m_en[n]};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the current input values
    task automatic model_edge();
        bit any_t, tick_t, wr, rd, fire, tick, rise;
        int sel;
        if (reset) begin
            for (int n = 0; n < 2; n++) begin
                m_en[n] = 0; m_mode[n] = 0; m_rpt[n] = 0; m_done[n] = 0;
                m_init[n] = 0; m_cur[n] = 0;
                for (int k = 0; k < 3; k++) m_hist[n][k] = 0;
            end
            m_pcnt  = 0;
            m_rdata = 0;
            m_irq   = 0;
            return;
        end
        any_t  = (m_en[0] && !m_mode[0]) || (m_en[1] && !m_mode[1]);
        tick_t = any_t && ((m_pcnt % PRESCALE) == PRESCALE - 1);
        wr     = ctc_cs && IOWrite;
        rd     = ctc_cs && IORead && !IOWrite;
        sel    = int'(addr[2:1]);
        if (rd) m_rdata = (sel < 2) ? status_word(sel) : m_cur[sel-2];
        m_irq = 2'b00;
        for (int n = 0; n < 2; n++) begin
            rise = m_hist[n][1] && !m_hist[n][2];
            fire = 0;
            if (wr && sel == n) begin
                m_en[n] = wdata[0]; m_mode[n] = wdata[1]; m_rpt[n] = wdata[2];
            end else if (wr && sel == n + 2) begin
                m_init[n] = wdata; m_cur[n] = wdata; m_done[n] = 0;
            end else begin
                tick = m_en[n] && (m_mode[n] ? rise : tick_t);
                if (tick && m_cur[n] > 1) begin
                    m_cur[n] = m_cur[n] - 1;
                end else if (tick && m_cur[n] == 1) begin
                    fire = 1;
                    m_done[n] = 1;
                    if (m_rpt[n]) m_cur[n] = m_init[n];
                    else begin m_cur[n] = 0; m_en[n] = 0; end
                end
                if (!fire && rd && sel == n) m_done[n] = 0;
            end
            m_irq[n] = fire && IRQ_ON;
            m_hist[n][2] = m_hist[n][1];
            m_hist[n][1] = m_hist[n][0];
            m_hist[n][0] = pulse_in[n];
        end
        m_pcnt = any_t ? m_pcnt + 1 : 0;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clock);
        #1;
        check("rdata_model", 32'(rdata), 32'(m_rdata));
        check("irq_model", 32'(irq), 32'(m_irq));
        for (int n = 0; n < 2; n++) if (irq[n] === 1'b1) irq_seen[n]++;
    endtask

    task automatic idle(int n);
        repeat (n) cycle();
    endtask

    task automatic wr(logic [2:0] a, logic [15:0] d);
        ctc_cs = 1; IOWrite = 1; IORead = 0; addr = a; wdata = d;
        cycle();
        ctc_cs = 0; IOWrite = 0;
    endtask

    task automatic rd(logic [2:0] a);
        ctc_cs = 1; IORead = 1; IOWrite = 0; addr = a;
        cycle();
        ctc_cs = 0; IORead = 0;
    endtask

    initial begin
        logic [15:0] exp_seq [5];
        int base;
        exp_seq = '{16'd1, 16'd2, 16'd1, 16'd2, 16'd1};
        irq_seen[0] = 0; irq_seen[1] = 0;
        reset = 1; ctc_cs = 0; IORead = 0; IOWrite = 0; addr = 0; wdata = 0;
        pulse_in = 2'b00;
        idle(2);
        reset = 0;

        // Reset state
        check("reset_rdata", 32'(rdata), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        rd(3'd0); check("status0_reset", 32'(rdata), 32'h8000);
        rd(3'd6); check("cur1_reset", 32'(rdata), 32'h0);

        // Timer mode, INIT0=3, prescale 4
        wr(3'd4, 16'd3);
        wr(3'd0, 16'h0001);
        base = irq_seen[0];
        ctc_cs = 1; IORead = 1; addr = 3'd4;
        for (int k = 1; k <= 14; k++) begin
            cycle();
            if (k == 4)  check("cur0_before_tick1", 32'(rdata), 32'd3);
            if (k == 5)  check("cur0_after_tick1", 32'(rdata), 32'd2);
            if (k == 9)  check("cur0_after_tick2", 32'(rdata), 32'd1);
            if (k == 13) check("cur0_after_tick3", 32'(rdata), 32'd0);
            if (k == 12) check("irq0_terminal", 32'(irq[0]), 32'(IRQ_ON));
            if (k == 13) check("irq0_one_cycle", 32'(irq[0]), 32'd0);
        end
        ctc_cs = 0; IORead = 0;
        check("irq0_count", 32'(irq_seen[0] - base), IRQ_ON ? 32'd1 : 32'd0);
        rd(3'd0); check("status0_done", 32'(rdata), 32'h8002);
        rd(3'd0); check("status0_cleared", 32'(rdata), 32'h8000);

        // Pulse counter with auto-reload on channel 1
        wr(3'd6, 16'd2);
        wr(3'd2, 16'h0007);
        base = irq_seen[1];
        for (int p = 0; p < 5; p++) begin
            pulse_in[1] = 1'b1; idle(3);
            pulse_in[1] = 1'b0; idle(3);
            rd(3'd7); check("cur1_pulse_seq", 32'(rdata), 32'(exp_seq[p]));
        end
        check("irq1_count", 32'(irq_seen[1] - base), IRQ_ON ? 32'd2 : 32'd0);
        rd(3'd2); check("status1_first", 32'(rdata), 32'h800F);
        rd(3'd2); check("status1_second", 32'(rdata), 32'h800D);

        // Terminal tick coinciding with a STATUS0 read: set wins
        wr(3'd4, 16'd1);
        wr(3'd0, 16'h0001);
        idle(3);
        rd(3'd0); check("status0_coincide_1", 32'(rdata), 32'h8001);
        rd(3'd0); check("status0_coincide_2", 32'(rdata), 32'h8002);

        // INIT write in the same cycle as a tick with CUR0=5
        wr(3'd4, 16'd6);
        wr(3'd0, 16'h0001);
        idle(7);
        wr(3'd4, 16'd7);
        rd(3'd4); check("cur0_write_wins", 32'(rdata), 32'd7);
        rd(3'd0); check("status0_write_wins", 32'(rdata), 32'h8001);

        // Reset just before a terminal tick: no irq, state cleared
        wr(3'd4, 16'd1);
        base = irq_seen[0];
        reset = 1; idle(3); reset = 0;
        idle(4);
        check("irq0_after_reset", 32'(irq_seen[0] - base), 32'd0);
        rd(3'd4); check("cur0_after_reset", 32'(rdata), 32'd0);
        rd(3'd0); check("status0_after_reset", 32'(rdata), 32'h8000);

        // Strobes without chip select are ignored
        ctc_cs = 0; IOWrite = 1; addr = 3'd4; wdata = 16'd9;
        cycle();
        IOWrite = 0;
        rd(3'd4); check("cur0_no_cs", 32'(rdata), 32'd0);

        // Read and write together: write happens, rdata holds
        wr(3'd6, 16'd5);
        rd(3'd7); check("cur1_setup", 32'(rdata), 32'd5);
        ctc_cs = 1; IORead = 1; IOWrite = 1; addr = 3'd4; wdata = 16'd12;
        cycle();
        ctc_cs = 0; IORead = 0; IOWrite = 0;
        check("rdata_hold_rw", 32'(rdata), 32'd5);
        rd(3'd4); check("cur0_rw_written", 32'(rdata), 32'd12);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            reset   = ($urandom_range(0, 299) == 0);
            ctc_cs  = ($urandom_range(0, 3) != 0);
            IORead  = ($urandom_range(0, 2) == 0);
            IOWrite = ($urandom_range(0, 3) == 0);
            addr    = 3'($urandom_range(0, 7));
            wdata   = addr[2] ? 16'($urandom_range(0, 6)) : 16'($urandom);
            if ($urandom_range(0, 3) == 0) pulse_in[0] = ~pulse_in[0];
            if ($urandom_range(0, 3) == 0) pulse_in[1] = ~pulse_in[1];
            cycle();
        end
        reset = 0; ctc_cs = 0; IORead = 0; IOWrite = 0; pulse_in = 2'b00;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
